md_issue_latch: RTL

MD_ISSUE_LATCH -- requirements
Module: md_issue_latch

---
 rtl/md_issue_latch.sv | 118 +++++++++++
 1 files changed

// File: rtl/md_issue_latch.sv
// Issue latch for a multi-cycle execution unit: captures one operation,
// launches it, tracks its latency and aborts it on flush or watchdog expiry.
module md_issue_latch #(
  parameter int DATA_W  = 32,
  parameter int IR_W    = 32,
  parameter int MAX_CYC = 40,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] d_a,
  input  logic [DATA_W-1:0] d_b,
  input  logic [IR_W-1:0]   d_ir,
  input  logic              result_ready,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic [IR_W-1:0]   q_ir,
  output logic              q_run,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYC - 1);

  state_e state, state_nxt;

  logic in_flight;
  logic accept;
  logic wd_hit;

  assign in_flight = (state == START) || (state == RUN);
  assign accept    = ((state == IDLE) || (state == DONE)) && en && !flush;
  // Watchdog fires only when the unit has not answered on this same edge.
  assign wd_hit    = (state == RUN) && !flush && !result_ready && (cycles == LAST_CYC);

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (flush)   state_nxt = IDLE;
        else if (en) state_nxt = START;
        else         state_nxt = IDLE;
      end
      START: state_nxt = flush ? IDLE : RUN;
      RUN: begin
        if (flush)                   state_nxt = IDLE;
        else if (result_ready)       state_nxt = DONE;
        else if (cycles == LAST_CYC) state_nxt = DONE;
        else                         state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, state only
  always_comb begin
    start = 1'b0;
    q_run = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      START: begin
        start = 1'b1;
        q_run = 1'b1;
        busy  = 1'b1;
      end
      RUN: begin
        q_run = 1'b1;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, latency counter and sticky watchdog flag
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_a     <= '0;
      q_b     <= '0;
      q_ir    <= '0;
      cycles  <= '0;
      timeout <= 1'b0;
    end else if (accept) begin
      q_a     <= d_a;
      q_b     <= d_b;
      q_ir    <= d_ir;
      cycles  <= '0;
      timeout <= 1'b0;
    end else if (in_flight && flush) begin
      // Aborted op leaves a bubble instruction; operands and latency stay visible.
      q_ir <= '0;
    end else if (in_flight) begin
      cycles <= cycles + 1'b1;
      if (wd_hit) timeout <= 1'b1;
    end
  end

endmodule
